// File: rtl/mod_counter_gen.sv
// Parametrised up/down modulo counter with prescaler,
// parallel load, wrap/saturate mode, tc pulse and sticky ovf.
module mod_counter_gen #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int PRESC   = 2,
  parameter int PRESC_W = $clog2(PRESC) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             tc,
  output logic             ovf
);

  // Top count value; fits in WIDTH even when MODULUS == 2^WIDTH.
  localparam logic [WIDTH-1:0]   MAX   = WIDTH'(MODULUS - 1);
  localparam logic [PRESC_W-1:0] PLAST = PRESC_W'(PRESC - 1);

  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;
  logic               tc_q, tc_d;
  logic               ovf_q, ovf_d;
  logic               step;
  logic               at_top;
  logic               at_bot;

  // Next-state: load beats step; a wrap beats clr_ovf.
  always_comb begin
    step    = en && (presc_q == PLAST);
    at_top  = (cnt_q == MAX);
    at_bot  = (cnt_q == '0);
    cnt_d   = cnt_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~clr_ovf;
    if (load) begin
      cnt_d   = (load_val > MAX) ? MAX : load_val;
      presc_d = '0;
    end else if (step) begin
      presc_d = '0;
      tick_d  = 1'b1;
      if (dir) begin
        if (at_top) begin
          tc_d = 1'b1;
          if (!sat_mode) begin
            cnt_d = '0;
            ovf_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (at_bot) begin
          tc_d = 1'b1;
          if (!sat_mode) begin
            cnt_d = MAX;
            ovf_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end else if (en) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out  = cnt_q;
  assign tick = tick_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/mod_counter_gen.md
Name: mod_counter_gen

Overview:
Parametrised modulo counter with an enable-gated prescaler. It counts up or down through 0..MODULUS-1 and supports parallel load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It is the generalised successor of the fixed 4-bit delayed modulo counter. It provides iteration and step sequencing for the CORDIC datapath controller.

Parameters:
WIDTH, 4, counter width in bits
MODULUS, 10, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2^WIDTH
PRESC, 2, enabled cycles per count step; PRESC=1 steps on every enabled cycle; legal range PRESC >= 1
PRESC_W, $clog2(PRESC)+1, prescaler counter width (derived)

Ports:
clk  input  1  rising-edge clock, the only clock
rst  input  1  synchronous active-high reset
en  input  1  advances the prescaler when high
dir  input  1  1 = count up, 0 = count down
sat_mode  input  1  1 = saturate at boundary, 0 = wrap
load  input  1  synchronous parallel load
load_val  input  WIDTH  value to load
clr_ovf  input  1  clears ovf
out  output  WIDTH  registered count value
tick  output  1  registered, high for the one cycle after each step
tc  output  1  registered, high for the one cycle after a boundary step
ovf  output  1  sticky wrap flag

Behaviour:
- All state updates on the rising edge of clk. Every output is a register.
- Internal state: presc_cnt (0..PRESC-1).
- Priority order on each edge: rst, then load, then step.
- rst=1: out=0, presc_cnt=0, tick=0, tc=0, ovf=0. A reset mid-count discards the prescaler phase.
- load=1, regardless of en:
  - out = load_val if load_val < MODULUS, otherwise out = MODULUS-1 (clamp).
  - presc_cnt=0; tick=0; tc=0; ovf unchanged.
  - A step that would occur in the same cycle is discarded.
- Step condition: en=1 and presc_cnt==PRESC-1. On a step, presc_cnt goes to 0 and tick=1 on the next cycle.
- en=1 without a step: presc_cnt increments.
- en=0: presc_cnt holds, tick=0 and tc=0 next cycle.
- Changing dir or sat_mode does not affect presc_cnt. Each step samples dir and sat_mode in the step cycle.
- Step up, out < MODULUS-1: out increments.
- Step up, out == MODULUS-1:
  - Wrap mode: out=0, tc=1, ovf set.
  - Saturate mode: out holds at MODULUS-1, tc=1, ovf unchanged.
- Step down, out > 0: out decrements.
- Step down, out == 0:
  - Wrap mode: out=MODULUS-1, tc=1, ovf set.
  - Saturate mode: out holds at 0, tc=1, ovf unchanged.
- In saturate mode, tc pulses on every blocked step, not only the first.
- tc and tick are 0 on any cycle that does not follow a step.
- ovf is cleared by clr_ovf. If a wrap and clr_ovf occur in the same cycle, set wins and ovf=1.
- The clamp on load guarantees that out never leaves 0..MODULUS-1. Arithmetic is WIDTH bits with no intermediate overflow, including the case MODULUS = 2^WIDTH.
- Latency: a step becomes visible on out, tick and tc on the edge that follows the qualifying enabled cycle.

Test Plan:
- Reset: hold rst=1 for 2 cycles with en=1 and load=1 -> out=0, tick=0, tc=0, ovf=0 throughout.
- Up wrap, defaults (MODULUS=10, PRESC=2), en=1, dir=1, sat_mode=0 from out=0:
  - out steps every 2 cycles: 1, 2, ..., 9, then 0 after 20 enabled cycles.
  - tick pulses 10 times; tc pulses once, on the 9->0 step; ovf=1 afterwards.
- Down wrap and sticky clear:
  - Load 0, then dir=0 -> after 2 enabled cycles out=9, tc=1, ovf=1.
  - Pulse clr_ovf -> ovf=0.
  - Pulse clr_ovf in the same cycle as the next 0->9 wrap -> ovf stays 1.
- Saturate and clamp:
  - Set sat_mode=1, load_val=12 -> out=9 (clamped).
  - Count up for 6 enabled cycles -> out stays 9, tc pulses 3 times, ovf unchanged.
  - Set dir=0 -> out steps down 8, 7, ...
- Prescaler phase:
  - With PRESC=3, toggle en 1,0,1,1 -> the step occurs only on the third enabled cycle.
  - Assert load on the step cycle -> out=load_val, no tick, presc_cnt=0.
- Reset mid-count: assert rst at out=5 with presc_cnt=1 -> next cycle out=0; the first subsequent step comes after a full PRESC enabled cycles.
